// File: rtl/sim_completion_monitor_if.sv
// Writeback/fetch observation bus and completion-status outputs of the end-of-test monitor.
interface sim_completion_monitor_if #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
);
    logic             wb_we_i;
    logic [4:0]       wb_rd_i;
    logic [XLEN-1:0]  wb_data_i;
    logic             retire_i;
    logic [XLEN-1:0]  pc_f_i;
    logic             done_o;
    logic [1:0]       status_o;
    logic             dump_req_o;
    logic             x0_warn_o;
    logic [7:0]       x0_wr_cnt_o;
    logic [CNT_W-1:0] cycle_cnt_o;
    logic [CNT_W-1:0] retire_cnt_o;

    modport master (
        output wb_we_i, wb_rd_i, wb_data_i, retire_i, pc_f_i,
        input  done_o, status_o, dump_req_o, x0_warn_o, x0_wr_cnt_o, cycle_cnt_o, retire_cnt_o
    );

    modport slave (
        input  wb_we_i, wb_rd_i, wb_data_i, retire_i, pc_f_i,
        output done_o, status_o, dump_req_o, x0_warn_o, x0_wr_cnt_o, cycle_cnt_o, retire_cnt_o
    );
endinterface

// File: rtl/sim_completion_monitor.sv
// End-of-test monitor: detects the pass signature write, watchdog timeout and PC stall,
// and keeps cycle / retirement / illegal-x0-write statistics.
//
// state | meaning
// RUN   | test executing; watching for signature, stall and timeout
// DRAIN | signature seen; letting the pipeline drain before declaring pass
// DONE  | terminal; status held, counters frozen until rst
module sim_completion_monitor #(
    parameter int              XLEN           = 64,
    parameter logic [4:0]      SIG_REG        = 5'd31,
    parameter logic [XLEN-1:0] SIG_VALUE      = 'h7FF,
    parameter int              TIMEOUT_CYCLES = 1000,
    parameter int              STALL_LIMIT    = 64,
    parameter int              DRAIN_CYCLES   = 10,
    parameter int              CNT_W          = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    sim_completion_monitor_if.slave mon
);
    localparam int SW = $clog2(STALL_LIMIT + 1);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t           state, state_n;
    logic [DW-1:0]    drain_cnt, drain_n;
    logic [1:0]       status_q, status_n;
    logic [SW-1:0]    stall_cnt;
    logic [XLEN-1:0]  last_pc;
    logic [CNT_W-1:0] cycle_cnt, retire_cnt;
    logic [7:0]       x0_cnt;
    logic             done_q, dump_q, warn_q;
    logic             sig_hit, pc_eq, x0_evt, active;

    assign sig_hit = mon.wb_we_i && (mon.wb_rd_i == SIG_REG) && (mon.wb_data_i == SIG_VALUE);
    assign pc_eq   = (mon.pc_f_i == last_pc);
    assign x0_evt  = mon.wb_we_i && (mon.wb_rd_i == 5'd0) && (mon.wb_data_i != '0);
    assign active  = (state != DONE);

    always_comb begin
        state_n  = state;
        drain_n  = drain_cnt;
        status_n = status_q;
        case (state)
            RUN: begin
                if (sig_hit) begin
                    state_n = DRAIN;
                    drain_n = DW'(DRAIN_CYCLES - 1);
                end else if (pc_eq && (stall_cnt == SW'(STALL_LIMIT - 1))) begin
                    state_n  = DONE;
                    status_n = 2'b11;
                end else if (cycle_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_n  = DONE;
                    status_n = 2'b10;
                end
            end
            DRAIN: begin
                if (drain_cnt == '0) begin
                    state_n  = DONE;
                    status_n = 2'b01;
                end else begin
                    drain_n = drain_cnt - 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            drain_cnt  <= '0;
            status_q   <= 2'b00;
            stall_cnt  <= '0;
            last_pc    <= mon.pc_f_i;
            cycle_cnt  <= '0;
            retire_cnt <= '0;
            x0_cnt     <= '0;
            done_q     <= 1'b0;
            dump_q     <= 1'b0;
            warn_q     <= 1'b0;
        end else begin
            state     <= state_n;
            drain_cnt <= drain_n;
            status_q  <= status_n;
            done_q    <= (state_n == DONE);
            dump_q    <= (state_n == DONE) && (state != DONE);
            warn_q    <= active && x0_evt;
            if (active) begin
                cycle_cnt <= cycle_cnt + 1'b1;
                if (mon.retire_i) retire_cnt <= retire_cnt + 1'b1;
                if (x0_evt && (x0_cnt != 8'hFF)) x0_cnt <= x0_cnt + 1'b1;
            end
            // stall tracking only meaningful while the test is still executing
            if (state == RUN) begin
                last_pc   <= mon.pc_f_i;
                stall_cnt <= pc_eq ? stall_cnt + 1'b1 : '0;
            end
        end
    end

    assign mon.done_o       = done_q;
    assign mon.status_o     = status_q;
    assign mon.dump_req_o   = dump_q;
    assign mon.x0_warn_o    = warn_q;
    assign mon.x0_wr_cnt_o  = x0_cnt;
    assign mon.cycle_cnt_o  = cycle_cnt;
    assign mon.retire_cnt_o = retire_cnt;
endmodule
